// File: rtl/clock_mode_controller_pkg.sv
// Shared definitions for the alarm-clock mode controller.
//   - field widths for hours / minutes / seconds
//   - mode encodings driven on the mode output
//   - field_sel codes
//   - button identifiers and the priority selector used by the FSM
package clock_mode_controller_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_ADJ_TIME  = 2'd1;
  localparam logic [1:0] MODE_ADJ_ALARM = 2'd2;
  localparam logic [1:0] MODE_RINGING   = 2'd3;

  localparam logic FIELD_MIN  = 1'b0;
  localparam logic FIELD_HOUR = 1'b1;

  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_C    = 3'd1,
    BTN_L    = 3'd2,
    BTN_R    = 3'd3,
    BTN_U    = 3'd4,
    BTN_D    = 3'd5
  } btn_t;

  // Only one button acts per cycle: C > L > R > U > D.
  function automatic btn_t btn_select(input logic c, input logic l, input logic r,
                                      input logic u, input logic d);
    btn_t sel;
    if (c) begin
      sel = BTN_C;
    end else if (l) begin
      sel = BTN_L;
    end else if (r) begin
      sel = BTN_R;
    end else if (u) begin
      sel = BTN_U;
    end else if (d) begin
      sel = BTN_D;
    end else begin
      sel = BTN_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/clock_mode_controller_wrap_incdec.sv
// wrap_incdec: combinational increment / decrement of a value modulo MOD.
//   value  in  W  current value (expected 0..MOD-1)
//   inc    out W  (value + 1) mod MOD
//   dec    out W  (value - 1) mod MOD
// Out-of-range inputs are folded back into range: inc gives 0, dec gives MOD-1.
module wrap_incdec #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] inc,
  output logic [W-1:0] dec
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  // Wrap-around increment and decrement of the input value.
  always_comb begin
    inc = '0;
    dec = '0;
    if (value >= TOP) begin
      inc = '0;
    end else begin
      inc = value + W'(1);
    end
    if ((value == '0) || (value > TOP)) begin
      dec = TOP;
    end else begin
      dec = value - W'(1);
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// clock_mode_controller: central FSM of the alarm clock.
// Sequences CLOCK / ADJ_TIME / ADJ_ALARM / RINGING from single-cycle button
// pulses, owns the edit and alarm-time registers, and issues a one-cycle load
// command to the timekeeping counter.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   btnC_p..btnR_p              one-cycle button pulses
//   tick_1hz                    one-cycle pulse per second
//   cur_hour/cur_min/cur_sec    running time from the counter
//   mode, field_sel             current mode and field being edited
//   disp_hour, disp_min         displayed time (current time or edit regs)
//   time_load, load_hour/min    one-cycle load command with values
//   alarm_en, alarm_ring        alarm armed / ringing
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int HOURS     = 24,
  parameter int MINUTES   = 60,
  parameter int RING_SECS = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btnC_p,
  input  logic              btnU_p,
  input  logic              btnD_p,
  input  logic              btnL_p,
  input  logic              btnR_p,
  input  logic              tick_1hz,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic [1:0]        mode,
  output logic              field_sel,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic              time_load,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MIN_W-1:0]  load_min,
  output logic              alarm_en,
  output logic              alarm_ring
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);

  logic [HOUR_W-1:0] edit_hour_r;
  logic [MIN_W-1:0]  edit_min_r;
  logic [HOUR_W-1:0] alarm_hour_r;
  logic [MIN_W-1:0]  alarm_min_r;
  logic [RING_W-1:0] ring_cnt_r;

  logic [HOUR_W-1:0] hour_inc;
  logic [HOUR_W-1:0] hour_dec;
  logic [MIN_W-1:0]  min_inc;
  logic [MIN_W-1:0]  min_dec;
  btn_t              btn;
  logic              alarm_match;

  assign btn = btn_select(btnC_p, btnL_p, btnR_p, btnU_p, btnD_p);

  assign alarm_match = alarm_en && (cur_hour == alarm_hour_r) && (cur_min == alarm_min_r) &&
                       (cur_sec == '0) && tick_1hz;

  wrap_incdec #(.MOD(HOURS), .W(HOUR_W)) u_hour_wrap (
    .value (edit_hour_r),
    .inc   (hour_inc),
    .dec   (hour_dec)
  );

  wrap_incdec #(.MOD(MINUTES), .W(MIN_W)) u_min_wrap (
    .value (edit_min_r),
    .inc   (min_inc),
    .dec   (min_dec)
  );

  // Display mux: running time outside the adjust modes, edit registers inside.
  always_comb begin
    disp_hour = cur_hour;
    disp_min  = cur_min;
    case (mode)
      MODE_ADJ_TIME, MODE_ADJ_ALARM: begin
        disp_hour = edit_hour_r;
        disp_min  = edit_min_r;
      end
      default: begin
        disp_hour = cur_hour;
        disp_min  = cur_min;
      end
    endcase
  end

  // Mode FSM with edit, alarm, load and ring-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= MODE_CLOCK;
      field_sel    <= FIELD_MIN;
      edit_hour_r  <= '0;
      edit_min_r   <= '0;
      alarm_hour_r <= '0;
      alarm_min_r  <= '0;
      alarm_en     <= 1'b0;
      alarm_ring   <= 1'b0;
      ring_cnt_r   <= '0;
      time_load    <= 1'b0;
      load_hour    <= '0;
      load_min     <= '0;
    end else begin
      time_load <= 1'b0;
      case (mode)
        MODE_CLOCK: begin
          case (btn)
            BTN_C: begin
              mode        <= MODE_ADJ_TIME;
              edit_hour_r <= cur_hour;
              edit_min_r  <= cur_min;
              field_sel   <= FIELD_MIN;
            end
            BTN_U: alarm_en <= ~alarm_en;
            // The match is only honoured on a cycle with no button pulse at all.
            BTN_NONE: begin
              if (alarm_match) begin
                mode       <= MODE_RINGING;
                alarm_ring <= 1'b1;
                ring_cnt_r <= '0;
              end
            end
            default: ;
          endcase
        end
        MODE_ADJ_TIME, MODE_ADJ_ALARM: begin
          case (btn)
            BTN_C: begin
              field_sel <= FIELD_MIN;
              if (mode == MODE_ADJ_TIME) begin
                // Commit the edited time, then reuse the edit regs for the alarm.
                time_load   <= 1'b1;
                load_hour   <= edit_hour_r;
                load_min    <= edit_min_r;
                edit_hour_r <= alarm_hour_r;
                edit_min_r  <= alarm_min_r;
                mode        <= MODE_ADJ_ALARM;
              end else begin
                alarm_hour_r <= edit_hour_r;
                alarm_min_r  <= edit_min_r;
                alarm_en     <= 1'b1;
                mode         <= MODE_CLOCK;
              end
            end
            BTN_L, BTN_R: field_sel <= ~field_sel;
            BTN_U: begin
              if (field_sel == FIELD_HOUR) begin
                edit_hour_r <= hour_inc;
              end else begin
                edit_min_r <= min_inc;
              end
            end
            BTN_D: begin
              if (field_sel == FIELD_HOUR) begin
                edit_hour_r <= hour_dec;
              end else begin
                edit_min_r <= min_dec;
              end
            end
            default: ;
          endcase
        end
        MODE_RINGING: begin
          if (btn != BTN_NONE) begin
            mode       <= MODE_CLOCK;
            alarm_ring <= 1'b0;
            ring_cnt_r <= '0;
          end else if (tick_1hz) begin
            // The tick that starts ringing is not counted; this one is tick N.
            if (ring_cnt_r == RING_LAST) begin
              mode       <= MODE_CLOCK;
              alarm_ring <= 1'b0;
              ring_cnt_r <= '0;
            end else begin
              ring_cnt_r <= ring_cnt_r + RING_W'(1);
            end
          end
        end
        default: begin
          mode       <= MODE_CLOCK;
          alarm_ring <= 1'b0;
          ring_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_controller.sv
// Scoreboard bench for clock_mode_controller. Stimulus pushes expected
// snapshots and expected load commands into queues; a monitor on the falling
// edge pops and compares whenever a snapshot is pending or time_load is high.
module tb_clock_mode_controller;

  localparam int RING = 60;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_C    = 5'b10000;
  localparam logic [4:0] B_L    = 5'b01000;
  localparam logic [4:0] B_R    = 5'b00100;
  localparam logic [4:0] B_U    = 5'b00010;
  localparam logic [4:0] B_D    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnC_p, btnU_p, btnD_p, btnL_p, btnR_p, tick_1hz;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [1:0] mode;
  logic       field_sel;
  logic [4:0] disp_hour;
  logic [5:0] disp_min;
  logic       time_load;
  logic [4:0] load_hour;
  logic [5:0] load_min;
  logic       alarm_en;
  logic       alarm_ring;

  typedef struct packed {
    logic [1:0] mode;
    logic       fs;
    logic [4:0] hour;
    logic [5:0] min;
    logic       aen;
    logic       ring;
    logic       tl;
  } snap_t;

  snap_t       exp_q[$];
  string       name_q[$];
  logic [10:0] load_q[$];

  int   checks = 0;
  int   passed = 0;
  logic end_req = 1'b0;
  logic end_done = 1'b0;

  clock_mode_controller #(.HOURS(24), .MINUTES(60), .RING_SECS(RING)) dut (
    .clk        (clk),
    .rst        (rst),
    .btnC_p     (btnC_p),
    .btnU_p     (btnU_p),
    .btnD_p     (btnD_p),
    .btnL_p     (btnL_p),
    .btnR_p     (btnR_p),
    .tick_1hz   (tick_1hz),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .mode       (mode),
    .field_sel  (field_sel),
    .disp_hour  (disp_hour),
    .disp_min   (disp_min),
    .time_load  (time_load),
    .load_hour  (load_hour),
    .load_min   (load_min),
    .alarm_en   (alarm_en),
    .alarm_ring (alarm_ring)
  );

  always #5 clk = ~clk;

  // Monitor: compares pending snapshots and every time_load pulse.
  always @(negedge clk) begin
    int          dc;
    int          dp;
    snap_t       act;
    snap_t       e;
    string       nm;
    logic [10:0] lv;
    dc = 0;
    dp = 0;
    act.mode = mode;
    act.fs   = field_sel;
    act.hour = disp_hour;
    act.min  = disp_min;
    act.aen  = alarm_en;
    act.ring = alarm_ring;
    act.tl   = time_load;
    if (time_load) begin
      dc++;
      if (load_q.size() == 0) begin
        $display("FAIL unexpected_load: got time_load=1 with %0d:%0d, expected no load", load_hour, load_min);
      end else begin
        lv = load_q.pop_front();
        if ({load_hour, load_min} == lv) dp++;
        else $display("FAIL load_value: got %0d:%0d, expected %0d:%0d", load_hour, load_min, lv[10:6], lv[5:0]);
      end
    end
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      dc++;
      if (act == e) dp++;
      else $display("FAIL %s: got mode=%0d fs=%0d disp=%0d:%0d aen=%0d ring=%0d tl=%0d, expected mode=%0d fs=%0d disp=%0d:%0d aen=%0d ring=%0d tl=%0d",
                    nm, act.mode, act.fs, act.hour, act.min, act.aen, act.ring, act.tl,
                    e.mode, e.fs, e.hour, e.min, e.aen, e.ring, e.tl);
    end
    if (end_req && !end_done) begin
      dc++;
      if (load_q.size() == 0) dp++;
      else $display("FAIL missing_load: got %0d loads outstanding, expected 0", load_q.size());
      end_done <= 1'b1;
    end
    checks <= checks + dc;
    passed <= passed + dp;
  end

  task automatic step(input logic [4:0] b, input logic t);
    @(posedge clk); #1;
    {btnC_p, btnL_p, btnR_p, btnU_p, btnD_p} = b;
    tick_1hz = t;
    @(posedge clk); #1;
    {btnC_p, btnL_p, btnR_p, btnU_p, btnD_p} = B_NONE;
    tick_1hz = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_st(input string nm, input logic [1:0] m, input logic f, input int h,
                           input int mi, input logic ae, input logic ar, input logic tl);
    snap_t s;
    s.mode = m;
    s.fs   = f;
    s.hour = 5'(h);
    s.min  = 6'(mi);
    s.aen  = ae;
    s.ring = ar;
    s.tl   = tl;
    exp_q.push_back(s);
    name_q.push_back(nm);
    @(negedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {btnC_p, btnL_p, btnR_p, btnU_p, btnD_p} = B_NONE;
    tick_1hz = 1'b0;
    cur_hour = 5'd12;
    cur_min  = 6'd34;
    cur_sec  = 6'd5;
    idle(3);
    rst = 1'b0;
    idle(3);
    expect_st("reset_state", 2'd0, 1'b0, 12, 34, 1'b0, 1'b0, 1'b0);

    // Time adjust with wrap on both fields.
    cur_hour = 5'd10;
    cur_min  = 6'd15;
    step(B_C, 1'b0);
    expect_st("enter_adj_time", 2'd1, 1'b0, 10, 15, 1'b0, 1'b0, 1'b0);
    step(B_R, 1'b0);
    expect_st("field_hours", 2'd1, 1'b1, 10, 15, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(B_U, 1'b0);
    expect_st("hour_wrap_up", 2'd1, 1'b1, 0, 15, 1'b0, 1'b0, 1'b0);
    step(B_L, 1'b0);
    for (int i = 0; i < 16; i++) step(B_D, 1'b0);
    expect_st("min_wrap_down", 2'd1, 1'b0, 0, 59, 1'b0, 1'b0, 1'b0);
    load_q.push_back({5'd0, 6'd59});
    step(B_C, 1'b0);
    expect_st("commit_time", 2'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    expect_st("load_one_cycle", 2'd2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Alarm adjust to 07:30.
    for (int i = 0; i < 30; i++) step(B_U, 1'b0);
    step(B_R, 1'b0);
    for (int i = 0; i < 7; i++) step(B_U, 1'b0);
    expect_st("alarm_edit", 2'd2, 1'b1, 7, 30, 1'b0, 1'b0, 1'b0);
    step(B_C, 1'b0);
    expect_st("commit_alarm", 2'd0, 1'b0, 10, 15, 1'b1, 1'b0, 1'b0);
    step(B_U, 1'b0);
    expect_st("alarm_toggle_off", 2'd0, 1'b0, 10, 15, 1'b0, 1'b0, 1'b0);
    step(B_U, 1'b0);
    expect_st("alarm_toggle_on", 2'd0, 1'b0, 10, 15, 1'b1, 1'b0, 1'b0);

    // Alarm match, dismissed by a button.
    cur_hour = 5'd7;
    cur_min  = 6'd30;
    cur_sec  = 6'd0;
    idle(1);
    expect_st("match_needs_tick", 2'd0, 1'b0, 7, 30, 1'b1, 1'b0, 1'b0);
    step(B_NONE, 1'b1);
    expect_st("ring_start", 2'd3, 1'b0, 7, 30, 1'b1, 1'b1, 1'b0);
    step(B_D, 1'b0);
    expect_st("ring_dismiss", 2'd0, 1'b0, 7, 30, 1'b1, 1'b0, 1'b0);

    // Ring timeout after exactly RING ticks.
    step(B_NONE, 1'b1);
    expect_st("ring_again", 2'd3, 1'b0, 7, 30, 1'b1, 1'b1, 1'b0);
    cur_sec = 6'd1;
    for (int i = 0; i < RING - 1; i++) step(B_NONE, 1'b1);
    expect_st("ring_before_timeout", 2'd3, 1'b0, 7, 30, 1'b1, 1'b1, 1'b0);
    step(B_NONE, 1'b1);
    expect_st("ring_timeout", 2'd0, 1'b0, 7, 30, 1'b1, 1'b0, 1'b0);
    step(B_NONE, 1'b1);
    expect_st("no_match_sec1", 2'd0, 1'b0, 7, 30, 1'b1, 1'b0, 1'b0);

    // Simultaneous pulses.
    step(B_C | B_U, 1'b0);
    expect_st("c_beats_u", 2'd1, 1'b0, 7, 30, 1'b1, 1'b0, 1'b0);
    step(B_U | B_D, 1'b0);
    expect_st("u_beats_d", 2'd1, 1'b0, 7, 31, 1'b1, 1'b0, 1'b0);
    step(B_R, 1'b0);
    for (int i = 0; i < 8; i++) step(B_D, 1'b0);
    expect_st("hour_wrap_down", 2'd1, 1'b1, 23, 31, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an edit; no load may appear.
    @(posedge clk); #3;
    rst = 1'b1;
    expect_st("async_reset", 2'd0, 1'b0, 7, 30, 1'b0, 1'b0, 1'b0);
    step(B_C, 1'b0);
    expect_st("c_during_reset", 2'd0, 1'b0, 7, 30, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(3);
    expect_st("after_reset", 2'd0, 1'b0, 7, 30, 1'b0, 1'b0, 1'b0);

    end_req = 1'b1;
    for (int i = 0; i < 10 && !end_done; i++) idle(1);
    idle(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
